// File: rtl/dat_wr_status_rx.sv
// Receives the write-CRC-status token and the following busy phase on DAT0,
// and reports one result per written block to the data-path controller.
module dat_wr_status_rx #(
  parameter int         BUSY_GAP  = 2,
  parameter logic [2:0] STATUS_OK = 3'b010
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sd_tick_i,
  input  logic       dat0_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       timeout_i,
  output logic       timeout_running_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic       crc_err_o,
  output logic       end_bit_err_o,
  output logic       timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_STATUS, S_END_BIT, S_GAP, S_BUSY, S_DONE
  } state_t;

  localparam logic [2:0] GAP_LAST = 3'(BUSY_GAP - 1);

  state_t     state_q, state_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] status_q, status_d;
  logic       crc_err_q, crc_err_d;
  logic       end_bit_err_q, end_bit_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       run_q, run_d;
  logic [2:0] token_next;

  assign token_next = {status_q[1:0], dat0_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (start_i) state_d = S_WAIT_START;
        S_WAIT_START: begin
          if (timeout_i)                  state_d = S_DONE;
          else if (sd_tick_i && !dat0_i)  state_d = S_STATUS;
        end
        S_STATUS:     if (sd_tick_i && bit_cnt_q == 2'd2) state_d = S_END_BIT;
        S_END_BIT:    if (sd_tick_i) state_d = S_GAP;
        S_GAP:        if (sd_tick_i && gap_cnt_q == GAP_LAST) state_d = S_BUSY;
        S_BUSY: begin
          // Timeout wins over a same-cycle end of busy.
          if (timeout_i)                 state_d = S_DONE;
          else if (sd_tick_i && dat0_i)  state_d = S_DONE;
        end
        S_DONE:       state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    status_d      = status_q;
    crc_err_d     = crc_err_q;
    end_bit_err_d = end_bit_err_q;
    timeout_err_d = timeout_err_q;
    if (abort_i) begin
      bit_cnt_d     = 2'd0;
      gap_cnt_d     = 3'd0;
      status_d      = 3'b000;
      crc_err_d     = 1'b0;
      end_bit_err_d = 1'b0;
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            status_d      = 3'b000;
            crc_err_d     = 1'b0;
            end_bit_err_d = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        S_WAIT_START: begin
          // A missing start bit is also reported as a bad (all-zero) token.
          if (timeout_i) begin
            timeout_err_d = 1'b1;
            crc_err_d     = 1'b1;
            status_d      = 3'b000;
          end else if (sd_tick_i && !dat0_i) begin
            bit_cnt_d = 2'd0;
          end
        end
        S_STATUS: begin
          if (sd_tick_i) begin
            status_d  = token_next;
            bit_cnt_d = bit_cnt_q + 2'd1;
            if (bit_cnt_q == 2'd2) crc_err_d = (token_next != STATUS_OK);
          end
        end
        S_END_BIT: begin
          if (sd_tick_i) begin
            end_bit_err_d = !dat0_i;
            gap_cnt_d     = 3'd0;
          end
        end
        S_GAP:   if (sd_tick_i) gap_cnt_d = gap_cnt_q + 3'd1;
        S_BUSY:  if (timeout_i) timeout_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // The running flag follows the current state, so it lags entry and exit by one cycle.
  assign run_d = !abort_i && (state_q == S_WAIT_START || state_q == S_BUSY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q     <= 2'd0;
      gap_cnt_q     <= 3'd0;
      status_q      <= 3'b000;
      crc_err_q     <= 1'b0;
      end_bit_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      status_q      <= status_d;
      crc_err_q     <= crc_err_d;
      end_bit_err_q <= end_bit_err_d;
      timeout_err_q <= timeout_err_d;
      run_q         <= run_d;
    end
  end

  assign timeout_running_o = run_q;
  assign status_o          = status_q;
  assign crc_err_o         = crc_err_q;
  assign end_bit_err_o     = end_bit_err_q;
  assign timeout_err_o     = timeout_err_q;

endmodule

// File: tb/tb_dat_wr_status_rx.sv
// Directed bench for dat_wr_status_rx: a phase-level reference model checked every
// cycle, plus literal expectations after each scenario.
module tb_dat_wr_status_rx;

  localparam int BUSY_GAP = 2;

  logic       clk, rst;
  logic       sd_tick, dat0, start, abort, timeout;
  logic       run, busy, done, crc_err, eb_err, to_err;
  logic [2:0] status;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int d0;

  dat_wr_status_rx #(.BUSY_GAP(BUSY_GAP), .STATUS_OK(3'b010)) dut (
    .clk_i(clk), .rst_i(rst), .sd_tick_i(sd_tick), .dat0_i(dat0),
    .start_i(start), .abort_i(abort), .timeout_i(timeout),
    .timeout_running_o(run), .busy_o(busy), .done_o(done),
    .status_o(status), .crc_err_o(crc_err), .end_bit_err_o(eb_err),
    .timeout_err_o(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 waiting for start bit, 2 token, 3 end bit,
  // 4 gap, 5 busy, 6 result cycle.
  int   m_phase, m_n, m_tok;
  logic m_crc, m_eb, m_to, m_run;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_n <= 0; m_tok <= 0;
      m_crc <= 0; m_eb <= 0; m_to <= 0; m_run <= 0;
    end else if (abort) begin
      m_phase <= 0; m_tok <= 0;
      m_crc <= 0; m_eb <= 0; m_to <= 0; m_run <= 0;
    end else begin
      m_run <= (m_phase == 1 || m_phase == 5);
      case (m_phase)
        0: if (start) begin m_phase <= 1; m_tok <= 0; m_crc <= 0; m_eb <= 0; m_to <= 0; end
        1: if (timeout) begin m_phase <= 6; m_to <= 1; m_crc <= 1; m_tok <= 0; end
           else if (sd_tick && !dat0) begin m_phase <= 2; m_n <= 0; end
        2: if (sd_tick) begin
             m_tok <= (m_tok * 2 + int'(dat0)) % 8;
             m_n <= m_n + 1;
             if (m_n == 2) begin
               m_phase <= 3;
               m_crc <= (((m_tok * 2 + int'(dat0)) % 8) != 2);
             end
           end
        3: if (sd_tick) begin m_eb <= !dat0; m_phase <= 4; m_n <= 0; end
        4: if (sd_tick) begin
             if (m_n == BUSY_GAP - 1) m_phase <= 5;
             m_n <= m_n + 1;
           end
        5: if (timeout) begin m_to <= 1; m_phase <= 6; end
           else if (sd_tick && dat0) m_phase <= 6;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == 6);
    chk("running", run, m_run);
    chk("status", status, m_tok[2:0]);
    chk("crc_err", crc_err, m_crc);
    chk("end_bit_err", eb_err, m_eb);
    chk("timeout_err", to_err, m_to);
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tk(input logic b);
    sd_tick = 1'b1; dat0 = b; step();
    sd_tick = 1'b0; step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic tks(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tk(bits[i]);
  endtask

  initial begin
    rst = 1'b1; sd_tick = 0; dat0 = 1; start = 0; abort = 0; timeout = 0;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("reset busy", busy, 0);
    chk("reset status", status, 3'b000);
    chk("reset running", run, 0);

    // Good write: 1,1,0 | 010 | end 1 | gap 1,1 | busy 0x5 | 1
    d0 = done_cnt;
    pulse_start();
    tks(16'b1100101, 7);
    chk("gap running low", run, 0);
    tks(16'b11, 2);
    tks(16'b000001, 6);
    chk("good done count", done_cnt - d0, 1);
    chk("good status", status, 3'b010);
    chk("good crc", crc_err, 0);
    chk("good eb", eb_err, 0);
    chk("good to", to_err, 0);
    step();

    // CRC-error token 101
    d0 = done_cnt;
    pulse_start();
    tks(16'b0101111, 7);
    tks(16'b01, 2);
    chk("crc done count", done_cnt - d0, 1);
    chk("crc status", status, 3'b101);
    chk("crc flag", crc_err, 1);
    chk("crc eb", eb_err, 0);
    step();

    // End-bit error, stray start during the gap
    d0 = done_cnt;
    pulse_start();
    tks(16'b00100, 5);
    pulse_start();
    tks(16'b11, 2);
    tks(16'b001, 3);
    chk("eb done count", done_cnt - d0, 1);
    chk("eb flag", eb_err, 1);
    chk("eb crc", crc_err, 0);
    chk("eb status", status, 3'b010);
    step();

    // No start bit, timeout after 20 cycles
    pulse_start();
    for (int i = 0; i < 10; i++) tk(1'b1);
    timeout = 1'b1; step(); timeout = 1'b0;
    chk("nostart done", done, 1);
    chk("nostart to", to_err, 1);
    step();
    chk("nostart busy after", busy, 0);
    chk("nostart crc", crc_err, 1);
    chk("nostart status", status, 3'b000);

    // Busy never ends; timeout and a dat0=1 tick together
    pulse_start();
    tks(16'b0010111, 7);
    tks(16'b000, 3);
    timeout = 1'b1; sd_tick = 1'b1; dat0 = 1'b1; step();
    timeout = 1'b0; sd_tick = 1'b0;
    chk("busy-to done", done, 1);
    chk("busy-to flag", to_err, 1);
    step();

    // Abort mid-token, then a clean good write
    d0 = done_cnt;
    pulse_start();
    tks(16'b00, 2);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort running", run, 0);
    chk("abort to cleared", to_err, 0);
    step(); step();
    chk("abort no done", done_cnt - d0, 0);
    pulse_start();
    tks(16'b1100101, 7);
    tks(16'b11, 2);
    tks(16'b000001, 6);
    chk("post-abort done count", done_cnt - d0, 1);
    chk("post-abort status", status, 3'b010);
    chk("post-abort crc", crc_err, 0);
    step();

    // Abort while in busy drops the running flag on the next cycle
    d0 = done_cnt;
    pulse_start();
    tks(16'b0010111, 7);
    tk(1'b0);
    chk("busy running high", run, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("busy abort running", run, 0);
    chk("busy abort idle", busy, 0);
    step();
    chk("busy abort no done", done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
